quad_enc_multi: RTL and testbench

QUAD_ENC_MULTI -- requirements
Module: quad_enc_multi

---
 rtl/quad_enc_multi.sv | 176 +++++++++++++++++
 tb/tb_quad_enc_multi.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_enc_multi.sv
// quad_enc_multi -- multi-channel quadrature encoder counter.
//
// Each channel synchronises and glitch-filters its A, B and index inputs,
// decodes A/B in x4 mode into an up/down count, captures the count on an
// index rising edge and compares the count against a programmable threshold.
// Pin-edge to count_o latency is 3 + FILT_LEN cycles.
//
// Ports
//   clk_i            sole clock, rising edge
//   reset_i          synchronous active-high reset
//   quadA_i/quadB_i  encoder phases, one bit per channel, asynchronous
//   index_i          encoder index, one bit per channel, asynchronous
//   wr_en_i          one-cycle register write strobe
//   wr_ch_i          write target channel
//   wr_sel_i         0 count, 1 threshold, 2 control, 3 ignored
//   wr_data_i        write data (control: bit0 enable, bit1 invert,
//                    bit2 idx_zero, bit3 clear sticky flags)
//   count_o          live counts, channel n at [n*CNT_W +: CNT_W]
//   latched_count_o  count captured on index rising edge, same packing
//   thresh_hit_o     registered count == threshold
//   index_seen_o     sticky index-edge flag
//   err_o            sticky illegal-transition flag
module quad_enc_multi #(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 32,
  parameter int FILT_LEN = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [NUM_CH-1:0]       quadA_i,
  input  logic [NUM_CH-1:0]       quadB_i,
  input  logic [NUM_CH-1:0]       index_i,
  input  logic                    wr_en_i,
  input  logic [2:0]              wr_ch_i,
  input  logic [1:0]              wr_sel_i,
  input  logic [CNT_W-1:0]        wr_data_i,
  output logic [NUM_CH*CNT_W-1:0] count_o,
  output logic [NUM_CH*CNT_W-1:0] latched_count_o,
  output logic [NUM_CH-1:0]       thresh_hit_o,
  output logic [NUM_CH-1:0]       index_seen_o,
  output logic [NUM_CH-1:0]       err_o
);

  // Filter counter terminal value: the filtered output flips on the
  // FILT_LEN-th consecutive cycle of disagreement.
  localparam logic [3:0] FILT_MAX   = 4'(FILT_LEN - 1);
  localparam logic [1:0] SEL_COUNT  = 2'd0;
  localparam logic [1:0] SEL_THRESH = 2'd1;
  localparam logic [1:0] SEL_CTRL   = 2'd2;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    // Bit order within each 3-bit bundle: [0] A, [1] B, [2] index.
    logic [2:0]       raw;
    logic [2:0]       sync1_q;
    logic [2:0]       sync2_q;
    logic [2:0]       filt;
    logic [2:0]       prev_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] latched_q;
    logic [CNT_W-1:0] thresh_q;
    logic [2:0]       ctrl_q;
    logic             err_q;
    logic             seen_q;
    logic             hit_q;
    logic             wr_hit;
    logic             a_chg;
    logic             b_chg;
    logic             step;
    logic             both;
    logic             dir_up;
    logic             idx_rise;

    assign raw = {index_i[n], quadB_i[n], quadA_i[n]};

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= raw;
        sync2_q <= sync1_q;
      end
    end

    for (genvar s = 0; s < 3; s++) begin : g_filt
      logic [3:0] fcnt_q;
      logic       filt_q;

      // Any cycle of agreement restarts the stability count.
      always_ff @(posedge clk_i) begin
        if (reset_i) begin
          fcnt_q <= '0;
          filt_q <= 1'b0;
        end else if (sync2_q[s] == filt_q) begin
          fcnt_q <= '0;
        end else if (fcnt_q == FILT_MAX) begin
          filt_q <= sync2_q[s];
          fcnt_q <= '0;
        end else begin
          fcnt_q <= fcnt_q + 4'd1;
        end
      end

      assign filt[s] = filt_q;
    end

    // x4 decode against the previous filtered phases. Both phases moving
    // together is an illegal transition and never counts.
    assign a_chg    = filt[0] ^ prev_q[0];
    assign b_chg    = filt[1] ^ prev_q[1];
    assign step     = a_chg ^ b_chg;
    assign both     = a_chg & b_chg;
    assign dir_up   = filt[0] ^ prev_q[1] ^ ctrl_q[1];
    assign idx_rise = filt[2] & ~prev_q[2];
    assign wr_hit   = wr_en_i && (wr_ch_i == 3'(n));

    // Priority: count write, then index zeroing, then step.
    always_comb begin
      count_d = count_q;
      if (wr_hit && (wr_sel_i == SEL_COUNT)) begin
        count_d = wr_data_i;
      end else if (idx_rise && ctrl_q[2]) begin
        count_d = '0;
      end else if (step && ctrl_q[0]) begin
        count_d = dir_up ? count_q + CNT_W'(1) : count_q - CNT_W'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        prev_q    <= '0;
        count_q   <= '0;
        latched_q <= '0;
        thresh_q  <= '1;
        ctrl_q    <= 3'b001;
        err_q     <= 1'b0;
        seen_q    <= 1'b0;
        hit_q     <= 1'b0;
      end else begin
        // Previous phases track even while the channel is disabled, so
        // re-enabling never produces a stale step.
        prev_q  <= filt;
        count_q <= count_d;
        hit_q   <= (count_q == thresh_q);
        if (idx_rise) begin
          latched_q <= count_q;
        end
        if (wr_hit && (wr_sel_i == SEL_THRESH)) begin
          thresh_q <= wr_data_i;
        end
        if (wr_hit && (wr_sel_i == SEL_CTRL)) begin
          ctrl_q <= wr_data_i[2:0];
          if (wr_data_i[3]) begin
            err_q  <= 1'b0;
            seen_q <= 1'b0;
          end
        end
        // A new event in the same cycle as a clear is kept, not lost.
        if (both) begin
          err_q <= 1'b1;
        end
        if (idx_rise) begin
          seen_q <= 1'b1;
        end
      end
    end

    assign count_o[n*CNT_W +: CNT_W]         = count_q;
    assign latched_count_o[n*CNT_W +: CNT_W] = latched_q;
    assign thresh_hit_o[n]                   = hit_q;
    assign index_seen_o[n]                   = seen_q;
    assign err_o[n]                          = err_q;
  end

endmodule

// File: tb/tb_quad_enc_multi.sv
// Directed testbench for quad_enc_multi (NUM_CH=4, CNT_W=32, FILT_LEN=4).
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_quad_enc_multi;
  localparam int NUM_CH   = 4;
  localparam int CNT_W    = 32;
  localparam int FILT_LEN = 4;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       qa;
  logic [NUM_CH-1:0]       qb;
  logic [NUM_CH-1:0]       idx;
  logic                    wr_en;
  logic [2:0]              wr_ch;
  logic [1:0]              wr_sel;
  logic [CNT_W-1:0]        wr_data;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH*CNT_W-1:0] latched;
  logic [NUM_CH-1:0]       hit;
  logic [NUM_CH-1:0]       seen;
  logic [NUM_CH-1:0]       err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  quad_enc_multi #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .quadA_i        (qa),
    .quadB_i        (qb),
    .index_i        (idx),
    .wr_en_i        (wr_en),
    .wr_ch_i        (wr_ch),
    .wr_sel_i       (wr_sel),
    .wr_data_i      (wr_data),
    .count_o        (count),
    .latched_count_o(latched),
    .thresh_hit_o   (hit),
    .index_seen_o   (seen),
    .err_o          (err)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] sel,
                    input logic [31:0] data);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_sel  = sel;
    wr_data = data;
    tick(1);
    wr_en   = 1'b0;
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return count[ch*CNT_W +: CNT_W];
  endfunction

  function automatic logic [31:0] lat(input int ch);
    return latched[ch*CNT_W +: CNT_W];
  endfunction

  logic [1:0]  fwd_ab [4];
  logic [1:0]  rev_ab [4];
  logic [31:0] rev_exp[4];

  initial begin
    reset = 1'b1; qa = '0; qb = '0; idx = '0;
    wr_en = 1'b0; wr_ch = '0; wr_sel = '0; wr_data = '0;
    fwd_ab  = '{2'b10, 2'b11, 2'b01, 2'b00};
    rev_ab  = '{2'b01, 2'b11, 2'b10, 2'b00};
    rev_exp = '{32'd3, 32'd2, 32'd1, 32'd0};

    // Reset state
    tick(3);
    check("rst_count",   count,   '0);
    check("rst_latched", latched, '0);
    check("rst_hit",     hit,     '0);
    check("rst_seen",    seen,    '0);
    check("rst_err",     err,     '0);
    reset = 1'b0;
    tick(2);

    // ch0 forward x4 sequence, each update exactly 7 cycles after the pin edge
    for (int i = 0; i < 4; i++) begin
      qa[0] = fwd_ab[i][1];
      qb[0] = fwd_ab[i][0];
      tick(6);
      check("fwd_before", cnt(0), 32'(i));
      tick(1);
      check("fwd_after", cnt(0), 32'(i + 1));
      tick(3);
    end
    check("fwd_final", cnt(0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      qa[0] = rev_ab[i][1];
      qb[0] = rev_ab[i][0];
      tick(6);
      check("rev_before", cnt(0), rev_exp[i] + 32'd1);
      tick(1);
      check("rev_after", cnt(0), rev_exp[i]);
      tick(3);
    end

    // 3-cycle glitch on ch1 A is filtered away
    qa[1] = 1'b1;
    tick(3);
    qa[1] = 1'b0;
    tick(12);
    check("glitch_count", cnt(1), 32'd0);
    check("glitch_err",   err,    4'b0000);

    // Simultaneous A/B change on ch2 flags an error and does not count
    qa[2] = 1'b1;
    qb[2] = 1'b1;
    tick(10);
    check("both_count", cnt(2), 32'd0);
    check("both_err",   err,    4'b0100);
    qa[2] = 1'b0;
    qb[2] = 1'b0;
    tick(10);
    wr(3'd2, 2'd2, 32'h9);
    check("err_clear", err, 4'b0000);

    // ch0 down from 0 wraps; threshold reset value is all-ones
    qb[0] = 1'b1;
    tick(7);
    check("wrap_down",     cnt(0), 32'hFFFF_FFFF);
    check("wrap_hit_late", hit,    4'b0000);
    tick(1);
    check("wrap_hit_max",  hit,    4'b0001);

    // Threshold 5, step up from 4, hit exactly one cycle after count==5
    wr(3'd0, 2'd1, 32'd5);
    wr(3'd0, 2'd0, 32'd4);
    check("load4", cnt(0), 32'd4);
    tick(1);
    check("hit_off_4", hit, 4'b0000);
    qb[0] = 1'b0;
    tick(6);
    check("up_before", cnt(0), 32'd4);
    tick(1);
    check("up_to_5",   cnt(0), 32'd5);
    check("hit_not_yet", hit,  4'b0000);
    wr(3'd0, 2'd0, 32'd9);
    check("hit_on",  hit,    4'b0001);
    check("load9",   cnt(0), 32'd9);
    tick(1);
    check("hit_off", hit,    4'b0000);

    // Ignored writes: reserved select and out-of-range channel
    wr(3'd0, 2'd3, 32'd55);
    check("sel3_ignored", cnt(0), 32'd9);
    wr(3'd5, 2'd0, 32'd55);
    check("ch5_ignored", count, {32'd0, 32'd0, 32'd0, 32'd9});

    // Index with idx_zero on ch3
    wr(3'd3, 2'd2, 32'h5);
    wr(3'd3, 2'd0, 32'd123);
    check("load123", cnt(3), 32'd123);
    idx[3] = 1'b1;
    tick(6);
    check("idx_seen_early", seen,   4'b0000);
    check("idx_cnt_early",  cnt(3), 32'd123);
    tick(1);
    check("idx_latched", lat(3), 32'd123);
    check("idx_zeroed",  cnt(3), 32'd0);
    check("idx_seen",    seen,   4'b1000);
    idx[3] = 1'b0;
    tick(10);
    check("idx_fall_cnt", cnt(3), 32'd0);
    check("idx_fall_lat", lat(3), 32'd123);

    // Count write collides with a step on ch3: write wins, step discarded
    qa[3] = 1'b1;
    tick(6);
    wr(3'd3, 2'd0, 32'd77);
    check("collide", cnt(3), 32'd77);
    tick(3);
    check("collide_hold", cnt(3), 32'd77);

    // Invert reverses direction on ch1
    wr(3'd1, 2'd2, 32'h3);
    qa[1] = 1'b1;
    tick(8);
    check("invert_down", cnt(1), 32'hFFFF_FFFF);
    check("invert_hit",  hit,    4'b0010);

    // Reset mid-filter on ch2, with all pins returned low during reset
    qa[2] = 1'b1;
    tick(3);
    reset = 1'b1;
    qa = '0; qb = '0; idx = '0;
    tick(1);
    check("mid_rst_count",   count,   '0);
    check("mid_rst_latched", latched, '0);
    check("mid_rst_hit",     hit,     '0);
    check("mid_rst_seen",    seen,    '0);
    check("mid_rst_err",     err,     '0);
    reset = 1'b0;
    tick(15);
    check("post_rst_count", count, '0);
    check("post_rst_err",   err,   '0);

    // Threshold back to all-ones after reset: count down to max on ch0
    qb[0] = 1'b1;
    tick(7);
    check("post_rst_wrap", cnt(0), 32'hFFFF_FFFF);
    tick(1);
    check("post_rst_hit", hit, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
